decoder_3to8_seq: RTL
=====================

DECODER_3TO8_SEQ -- requirements
Module: decoder_3to8_seq

Interface
REQ-001 SHALL provide parameter HOLD, default 2: cycles the one-hot output stays asserted per accepted code; legal range 1..15.
REQ-002 SHALL provide parameter GAP, default 1: idle cycles inserted after each drive window; legal range 0..15.
REQ-003 SHALL provide port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  code on y2..y0 is valid this cycle.
REQ-006 SHALL provide port in_ready  output  1  block can accept a code this cycle.
REQ-007 SHALL provide ports y2, y1, y0  input  1 each  binary code; y2 is the MSB.
REQ-008 SHALL provide ports a7..a0  output  1 each  registered one-hot decode; a[k] corresponds to code k.
REQ-009 SHALL provide port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL provide port done  output  1  one-cycle pulse marking the last drive cycle.

Function
REQ-011 SHALL implement states IDLE, DRIVE and GAP, using a 4-bit down-counter for window timing.
REQ-012 SHALL drive in_ready = 1 only in IDLE; inputs presented in DRIVE or GAP SHALL be ignored, with no buffering.
REQ-013 SHALL accept a code on any rising edge where in_valid = 1 and in_ready = 1, capture {y2,y1,y0}, load the counter with HOLD, and enter DRIVE.
REQ-014 SHALL assert exactly one of a7..a0, the one matching the captured code, from the first cycle after acceptance for exactly HOLD cycles.
REQ-015 SHALL hold a7..a0 all zero in IDLE and in GAP.
REQ-016 SHALL assert done during the final DRIVE cycle only.
REQ-017 SHALL enter GAP after the final DRIVE cycle when GAP > 0, staying there GAP cycles before returning to IDLE; when GAP = 0 it SHALL go directly to IDLE.
REQ-018 SHALL treat HOLD = 0 as HOLD = 1.
REQ-019 SHALL, when in_valid is held high continuously, accept one code every HOLD + GAP + 1 cycles.
REQ-020 SHALL keep the captured code stable throughout DRIVE, even if y2..y0 change.

Reset
REQ-021 SHALL, on any edge with rst = 1, enter IDLE, clear the counter and captured code, and drive a7..a0 = 0, done = 0, busy = 0.
REQ-022 SHALL drive in_ready = 1 in the first cycle after rst deasserts.
REQ-023 SHALL, on rst asserted mid-DRIVE or mid-GAP, abort the operation with no done pulse and discard the captured code.
REQ-024 SHALL give rst priority over a simultaneous in_valid handshake, so the code is not accepted.

Configuration
REQ-025 SHALL support macro DECODER_PARITY_EN.
REQ-026 SHALL, when DECODER_PARITY_EN is defined, add ports y_par (input, 1) and err (output, 1).
REQ-027 SHALL, when DECODER_PARITY_EN is defined, require even parity over {y2,y1,y0,y_par} at acceptance.
REQ-028 SHALL, on a parity failure, perform no DRIVE and no done, pulse err for one cycle, and then follow the GAP/IDLE path as if the drive window had ended.
REQ-029 SHALL, when DECODER_PARITY_EN is undefined, omit y_par and err and accept every code.

Verification
REQ-030 SHALL cover: reset, then each code 0..7 with HOLD=2, GAP=1 -> a[k] high for exactly 2 cycles, done on the 2nd cycle, period 4 cycles.
REQ-031 SHALL cover: in_valid held high with code 5 while y toggles during DRIVE -> only a5 asserts, and in_ready is low for 3 of every 4 cycles.
REQ-032 SHALL cover: HOLD=1, GAP=0, back-to-back codes 3 then 6 -> a3 for 1 cycle, 1 IDLE cycle, then a6 for 1 cycle.
REQ-033 SHALL cover: rst asserted on the 2nd DRIVE cycle of code 7 with HOLD=4 -> a7 = 0 at the next edge, no done pulse, in_ready = 1 after rst deasserts.
REQ-034 SHALL cover, with DECODER_PARITY_EN defined: code 1 with y_par=0 -> err pulses, a7..a0 stay 0; code 1 with y_par=1 -> a1 asserts normally.
REQ-035 SHALL cover: in_valid and rst high on the same edge -> no acceptance, outputs all zero.

Source files
------------

// File: rtl/decoder_3to8_seq.sv
// decoder_3to8_seq: handshaked 3-to-8 decoder that holds each one-hot code for HOLD cycles and then idles for GAP cycles; optional parity check under DECODER_PARITY_EN
module decoder_3to8_seq #(
   parameter int HOLD = 2,
   parameter int GAP  = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic y2,
   input  logic y1,
   input  logic y0,
   output logic a7,
   output logic a6,
   output logic a5,
   output logic a4,
   output logic a3,
   output logic a2,
   output logic a1,
   output logic a0,
   output logic busy,
   output logic done
`ifdef DECODER_PARITY_EN
   ,
   input  logic y_par,
   output logic err
`endif
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [3:0] HOLD_CNT = (HOLD == 0) ? 4'd1 : 4'(HOLD);
   localparam logic [3:0] GAP_CNT  = 4'(GAP);
   logic [1:0] r_state;
   logic [3:0] r_cnt;
   logic [2:0] r_code;
   logic       w_acc;
   logic       w_par_ok;
   logic       w_last;
   logic [7:0] w_a;
   assign in_ready = r_state == S_IDLE;
   assign busy     = r_state != S_IDLE;
   assign w_acc    = in_valid && in_ready;
   assign w_last   = r_cnt == 4'd1;
   assign done     = r_state == S_DRIVE && w_last;
   assign w_a      = (r_state == S_DRIVE) ? (8'd1 << r_code) : 8'd0;
   assign {a7, a6, a5, a4, a3, a2, a1, a0} = w_a;
`ifdef DECODER_PARITY_EN
   assign w_par_ok = ~^{y2, y1, y0, y_par};
   logic r_err;
   assign err = r_err;
   // one-cycle error pulse for a code accepted with bad parity
   always_ff @(posedge clk) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= w_acc && !w_par_ok;
   end
`else
   assign w_par_ok = 1'b1;
`endif
   // IDLE/DRIVE/GAP sequencing with a shared down-counter for both windows
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_code  <= 3'd0;
      end else if (w_acc) begin
         r_code <= {y2, y1, y0};
         if (w_par_ok) begin
            r_state <= S_DRIVE;
            r_cnt   <= HOLD_CNT;
         end else begin
            r_state <= (GAP_CNT != 4'd0) ? S_GAP : S_IDLE;
            r_cnt   <= GAP_CNT;
         end
      end else if (r_state != S_IDLE) begin
         if (w_last) begin
            r_state <= (r_state == S_DRIVE && GAP_CNT != 4'd0) ? S_GAP : S_IDLE;
            r_cnt   <= (r_state == S_DRIVE) ? GAP_CNT : 4'd0;
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end
endmodule
